// File: rtl/schmidl_cox_pkg.sv
// Shared widths and window-state encoding for the Schmidl-Cox correlator datapath.
// Default chain: 16-bit samples, 33-bit products, 41-bit windowed sums over 2^8 beats.
package schmidl_cox_pkg;

    localparam int SC_WIDTH_SAMPLE = 16;
    localparam int SC_WIDTH_IN     = 33;
    localparam int SC_WIDTH_OUT    = 41;
    localparam int SC_WINDOW_LOG2  = 8;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } win_state_t;

endpackage

// File: rtl/sc_delay_line.sv
// Circular sample store, read-before-write, registered read (1 cycle) for block-RAM inference.
// No flow control of its own: the caller supplies the write enable and a look-ahead read address.
module sc_delay_line #(
    parameter int DEPTH_LOG2 = 8,
    parameter int WIDTH      = 66
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [DEPTH_LOG2-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]      wr_dat_i,
    input  logic [DEPTH_LOG2-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_dat_o
);

    logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    // Contents are deliberately left unreset; the consumer masks them until the window is full.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
        rd_dat_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/complex_moving_sum.sv
// Complex sliding-window sum over 2^WINDOW_LOG2 beats; one output beat per accepted input, 1-cycle latency.
// i_tready = !o_tvalid || o_tready (low during clear); a stalled output holds and blocks input.
module complex_moving_sum
    import schmidl_cox_pkg::*;
#(
    parameter int WIDTH_IN    = SC_WIDTH_IN,
    parameter int WINDOW_LOG2 = SC_WINDOW_LOG2,
    parameter int WIDTH_OUT   = WIDTH_IN + WINDOW_LOG2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic [2*WIDTH_IN-1:0]  i_tdata,
    input  logic                   i_tlast,
    input  logic                   i_tvalid,
    output logic                   i_tready,
    output logic [2*WIDTH_OUT-1:0] o_tdata,
    output logic                   o_tlast,
    output logic                   o_tvalid,
    input  logic                   o_tready
);

    localparam int N     = 1 << WINDOW_LOG2;
    localparam int CNT_W = WINDOW_LOG2 + 1;
    localparam int EXT_W = WIDTH_OUT - WIDTH_IN;

    generate
        if (WIDTH_OUT != WIDTH_IN + WINDOW_LOG2) begin : g_bad_width
            $error("complex_moving_sum: WIDTH_OUT must equal WIDTH_IN + WINDOW_LOG2");
        end
        if (WINDOW_LOG2 < 1) begin : g_bad_window
            $error("complex_moving_sum: WINDOW_LOG2 must be at least 1");
        end
    endgenerate

    function automatic logic [WIDTH_OUT-1:0] sext(input logic [WIDTH_IN-1:0] x);
        return {{EXT_W{x[WIDTH_IN-1]}}, x};
    endfunction

    win_state_t             state_q;
    logic [WINDOW_LOG2-1:0] ptr_q, ptr_d, rd_addr;
    logic [CNT_W-1:0]       fill_cnt_q;
    logic [WIDTH_OUT-1:0]   acc_re_q, acc_im_q, acc_re_d, acc_im_d;
    logic                   o_tvalid_q, o_tlast_q;
    logic                   accept;
    logic [2*WIDTH_IN-1:0]  oldest_dat;
    logic [WIDTH_IN-1:0]    new_re, new_im, old_re, old_im;

    assign i_tready = (!o_tvalid_q || o_tready) && !clear;
    assign accept   = i_tvalid && i_tready;

    assign new_re = i_tdata[2*WIDTH_IN-1:WIDTH_IN];
    assign new_im = i_tdata[WIDTH_IN-1:0];

    // Until N beats have been seen the stored entry predates the window, so it contributes zero.
    assign old_re = (state_q == ST_RUN) ? oldest_dat[2*WIDTH_IN-1:WIDTH_IN] : '0;
    assign old_im = (state_q == ST_RUN) ? oldest_dat[WIDTH_IN-1:0]          : '0;

    always_comb begin
        ptr_d    = accept ? ptr_q + 1'b1 : ptr_q;
        acc_re_d = acc_re_q + sext(new_re) - sext(old_re);
        acc_im_d = acc_im_q + sext(new_im) - sext(old_im);
    end

    // Look-ahead read keeps the entry at ptr_q on the RAM output ahead of the next accepted beat.
    assign rd_addr = clear ? '0 : ptr_d;

    sc_delay_line #(
        .DEPTH_LOG2 (WINDOW_LOG2),
        .WIDTH      (2*WIDTH_IN)
    ) u_delay_line (
        .clk       (clk),
        .wr_en_i   (accept),
        .wr_addr_i (ptr_q),
        .wr_dat_i  (i_tdata),
        .rd_addr_i (rd_addr),
        .rd_dat_o  (oldest_dat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_FILL;
            ptr_q      <= '0;
            fill_cnt_q <= '0;
            acc_re_q   <= '0;
            acc_im_q   <= '0;
            o_tvalid_q <= 1'b0;
            o_tlast_q  <= 1'b0;
        end else if (clear) begin
            state_q    <= ST_FILL;
            ptr_q      <= '0;
            fill_cnt_q <= '0;
            acc_re_q   <= '0;
            acc_im_q   <= '0;
            o_tvalid_q <= 1'b0;
            o_tlast_q  <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            if (accept) begin
                acc_re_q   <= acc_re_d;
                acc_im_q   <= acc_im_d;
                o_tvalid_q <= 1'b1;
                o_tlast_q  <= i_tlast;
                if (state_q == ST_FILL) begin
                    fill_cnt_q <= fill_cnt_q + 1'b1;
                    if (fill_cnt_q == CNT_W'(N - 1)) begin
                        state_q <= ST_RUN;
                    end
                end
            end else if (o_tready) begin
                o_tvalid_q <= 1'b0;
            end
        end
    end

    assign o_tdata  = {acc_re_q, acc_im_q};
    assign o_tvalid = o_tvalid_q;
    assign o_tlast  = o_tlast_q;

endmodule

// File: tb/tb_complex_moving_sum.sv
// Directed bench for complex_moving_sum with an 8-beat window and 33-bit input components.
module tb_complex_moving_sum;

    localparam int WI = 33;
    localparam int WL = 3;
    localparam int WO = WI + WL;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            clear;
    logic [2*WI-1:0] i_tdata;
    logic            i_tlast;
    logic            i_tvalid;
    logic            i_tready;
    logic [2*WO-1:0] o_tdata;
    logic            o_tlast;
    logic            o_tvalid;
    logic            o_tready;

    int errors = 0;
    int checks = 0;

    complex_moving_sum #(
        .WIDTH_IN    (WI),
        .WINDOW_LOG2 (WL),
        .WIDTH_OUT   (WO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready)
    );

    always #5 clk = ~clk;

    function automatic longint lmin(input longint a, input longint b);
        return (a < b) ? a : b;
    endfunction

    // Drive one cycle at the falling edge, then sample the handshakes that the next rising edge will act on.
    task automatic step(input logic vld, input longint re, input longint im, input logic last,
                        input logic rdy, input logic clr,
                        output logic in_acc, output logic out_acc, output logic ovld,
                        output logic [WO-1:0] ore, output logic [WO-1:0] oim, output logic olast);
        @(negedge clk);
        i_tvalid = vld;
        i_tdata  = {WI'(re), WI'(im)};
        i_tlast  = last;
        o_tready = rdy;
        clear    = clr;
        #1;
        in_acc  = i_tvalid && i_tready;
        out_acc = o_tvalid && o_tready;
        ovld    = o_tvalid;
        ore     = o_tdata[2*WO-1:WO];
        oim     = o_tdata[WO-1:0];
        olast   = o_tlast;
    endtask

    task automatic do_clear();
        logic ia, oa, ov, ol;
        logic [WO-1:0] r, i;
        step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, ia, oa, ov, r, i, ol);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clear = 1'b0; i_tvalid = 1'b1; i_tdata = '1; i_tlast = 1'b1; o_tready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (o_tvalid !== 1'b0 || o_tlast !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: got vld=%b last=%b want 0 0", o_tvalid, o_tlast);
        end
        checks++;
        if (o_tdata !== '0) begin
            errors++; $display("FAIL reset_data: got %h want 0", o_tdata);
        end
        i_tvalid = 1'b0; i_tlast = 1'b0; i_tdata = '0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (i_tready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", i_tready);
        end
    endtask

    task automatic test_constant();
        logic ia, oa, ov, ol;
        logic [WO-1:0] r, i;
        for (int c = 0; c <= 20; c++) begin
            step(c < 20, 1, -1, 1'b0, 1'b1, 1'b0, ia, oa, ov, r, i, ol);
            if (c < 20) begin
                checks++;
                if (ia !== 1'b1) begin
                    errors++; $display("FAIL const_accept beat %0d: got %b want 1", c, ia);
                end
            end
            if (c >= 1) begin
                checks++;
                if (oa !== 1'b1 || {r, i} !== {WO'(lmin(c, 8)), WO'(-lmin(c, 8))}) begin
                    errors++;
                    $display("FAIL const_sum out %0d: got vld=%b (%0d,%0d) want (%0d,%0d)",
                             c - 1, oa, $signed(r), $signed(i), lmin(c, 8), -lmin(c, 8));
                end
            end
        end
    endtask

    task automatic test_impulse();
        logic ia, oa, ov, ol;
        logic [WO-1:0] r, i;
        longint e;
        do_clear();
        for (int c = 0; c <= 12; c++) begin
            step(c < 12, (c == 0) ? 1000 : 0, (c == 0) ? -1000 : 0, 1'b0, 1'b1, 1'b0,
                 ia, oa, ov, r, i, ol);
            if (c >= 1) begin
                e = (c - 1 < 8) ? 1000 : 0;
                checks++;
                if (oa !== 1'b1 || {r, i} !== {WO'(e), WO'(-e)}) begin
                    errors++;
                    $display("FAIL impulse out %0d: got vld=%b (%0d,%0d) want (%0d,%0d)",
                             c - 1, oa, $signed(r), $signed(i), e, -e);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic ia, oa, ov, ol, rdy, prev_stall;
        logic [WO-1:0] r, i, pr, pi;
        longint vr[16], vi[16];
        longint er, ei;
        int sent, got, idx;
        for (int k = 0; k < 16; k++) begin
            vr[k] = 7 * k - 20;
            vi[k] = 100 - k * k;
        end
        do_clear();
        sent = 0; got = 0; prev_stall = 1'b0; pr = '0; pi = '0;
        for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
            rdy = 1'($urandom_range(0, 1));
            idx = (sent < 16) ? sent : 15;
            step(sent < 16, vr[idx], vi[idx], 1'b0, rdy, 1'b0, ia, oa, ov, r, i, ol);
            if (prev_stall) begin
                checks++;
                if (ov !== 1'b1 || r !== pr || i !== pi) begin
                    errors++;
                    $display("FAIL bp_hold: got vld=%b (%0d,%0d) want 1 (%0d,%0d)",
                             ov, $signed(r), $signed(i), $signed(pr), $signed(pi));
                end
            end
            if (ov && !rdy) begin
                checks++;
                if (ia !== 1'b0) begin
                    errors++; $display("FAIL bp_accept_in_stall: got %b want 0", ia);
                end
            end
            if (ia) sent++;
            if (oa) begin
                er = 0; ei = 0;
                for (int j = (got > 7) ? got - 7 : 0; j <= got; j++) begin
                    er += vr[j];
                    ei += vi[j];
                end
                checks++;
                if ({r, i} !== {WO'(er), WO'(ei)}) begin
                    errors++;
                    $display("FAIL bp_sum out %0d: got (%0d,%0d) want (%0d,%0d)",
                             got, $signed(r), $signed(i), er, ei);
                end
                got++;
            end
            prev_stall = ov && !rdy;
            pr = r;
            pi = i;
        end
        checks++;
        if (got != 16 || sent != 16) begin
            errors++; $display("FAIL bp_count: got out=%0d in=%0d want 16 16", got, sent);
        end
        step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, ia, oa, ov, r, i, ol);
        checks++;
        if (ov !== 1'b0) begin
            errors++; $display("FAIL bp_extra_beat: got vld=%b want 0", ov);
        end
    endtask

    task automatic test_extreme();
        logic ia, oa, ov, ol;
        logic [WO-1:0] r, i;
        longint mn, e;
        mn = -(64'sd1 <<< (WI - 1));
        do_clear();
        for (int c = 0; c <= 10; c++) begin
            step(c < 10, mn, mn, 1'b0, 1'b1, 1'b0, ia, oa, ov, r, i, ol);
            if (c >= 1) begin
                e = mn * lmin(c, 8);
                checks++;
                if (oa !== 1'b1 || {r, i} !== {WO'(e), WO'(e)}) begin
                    errors++;
                    $display("FAIL extreme out %0d: got vld=%b (%0d,%0d) want (%0d,%0d)",
                             c - 1, oa, $signed(r), $signed(i), e, e);
                end
            end
        end
    endtask

    task automatic test_clear();
        logic ia, oa, ov, ol;
        logic [WO-1:0] r, i;
        do_clear();
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1, -1, 1'b0, 1'b1, 1'b0, ia, oa, ov, r, i, ol);
        end
        step(1'b1, 1, -1, 1'b0, 1'b1, 1'b1, ia, oa, ov, r, i, ol);
        checks++;
        if ({r, i} !== {WO'(5), WO'(-5)}) begin
            errors++; $display("FAIL clear_pre_sum: got (%0d,%0d) want (5,-5)", $signed(r), $signed(i));
        end
        checks++;
        if (ia !== 1'b0 || i_tready !== 1'b0) begin
            errors++; $display("FAIL clear_ready: got acc=%b rdy=%b want 0 0", ia, i_tready);
        end
        step(1'b1, 1, -1, 1'b0, 1'b1, 1'b0, ia, oa, ov, r, i, ol);
        checks++;
        if (ov !== 1'b0 || ia !== 1'b1) begin
            errors++; $display("FAIL clear_flush: got vld=%b acc=%b want 0 1", ov, ia);
        end
        step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, ia, oa, ov, r, i, ol);
        checks++;
        if (oa !== 1'b1 || {r, i} !== {WO'(1), WO'(-1)}) begin
            errors++;
            $display("FAIL clear_restart: got vld=%b (%0d,%0d) want (1,-1)", oa, $signed(r), $signed(i));
        end
    endtask

    task automatic test_tlast();
        logic ia, oa, ov, ol;
        logic [WO-1:0] r, i;
        do_clear();
        for (int c = 0; c <= 12; c++) begin
            step(c < 12, 1, -1, c == 9, 1'b1, 1'b0, ia, oa, ov, r, i, ol);
            if (c >= 1) begin
                checks++;
                if (ol !== 1'(c - 1 == 9) || {r, i} !== {WO'(lmin(c, 8)), WO'(-lmin(c, 8))}) begin
                    errors++;
                    $display("FAIL tlast out %0d: got last=%b (%0d,%0d) want last=%b (%0d,%0d)",
                             c - 1, ol, $signed(r), $signed(i), (c - 1 == 9), lmin(c, 8), -lmin(c, 8));
                end
            end
        end
    endtask

    task automatic test_midstream_reset();
        logic ia, oa, ov, ol;
        logic [WO-1:0] r, i;
        do_clear();
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 50, 60, 1'b0, 1'b1, 1'b0, ia, oa, ov, r, i, ol);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (o_tvalid !== 1'b0 || o_tdata !== '0) begin
            errors++; $display("FAIL midreset_flush: got vld=%b data=%h want 0 0", o_tvalid, o_tdata);
        end
        i_tvalid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            step(c < 3, 2, -2, 1'b0, 1'b1, 1'b0, ia, oa, ov, r, i, ol);
            if (c >= 1) begin
                checks++;
                if (oa !== 1'b1 || {r, i} !== {WO'(2 * c), WO'(-2 * c)}) begin
                    errors++;
                    $display("FAIL midreset_restart out %0d: got vld=%b (%0d,%0d) want (%0d,%0d)",
                             c - 1, oa, $signed(r), $signed(i), 2 * c, -2 * c);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_impulse();
        test_backpressure();
        test_extreme();
        test_clear();
        test_tlast();
        test_midstream_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
